cordic_op_sequencer: RTL and testbench
======================================

Name: cordic_op_sequencer

Overview:
Operand sequencer that sits directly upstream of recon_top_level (reconfigurable CORDIC core).
- Accepts one CORDIC request (X, Y, Z, sel) over a valid/ready handshake.
- Loads the operands into the core, pulses the core's reset to start an iteration run, and waits a fixed LATENCY.
- Captures the core's z output and returns it on a valid/ready response channel, one operation at a time.

Parameters:
WIDTH, 15, MSB index of data words; data width is WIDTH+1 (Q7.8 fixed point at default)
LATENCY, 32, cycles from core reset release to valid core z; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
ext_reset  in  1  asynchronous, active-high reset
req_valid  in  1  request operands valid
req_ready  out  1  sequencer can accept a request
req_x  in  WIDTH+1  X operand
req_y  in  WIDTH+1  Y operand
req_z  in  WIDTH+1  Z operand
req_sel  in  2  CORDIC mode select
core_xo  out  WIDTH+1  to recon_top_level Xo
core_yo  out  WIDTH+1  to recon_top_level Yo
core_zo  out  WIDTH+1  to recon_top_level Zo
core_sel  out  2  to recon_top_level sel
core_reset  out  1  to recon_top_level ext_reset (active high)
core_z  in  WIDTH+1  from recon_top_level z
rsp_valid  out  1  result valid
rsp_ready  in  1  consumer accepts result
rsp_data  out  WIDTH+1  captured core z
rsp_sel  out  2  sel of the operation that produced rsp_data
busy  out  1  high in every state except IDLE
op_count  out  16  completed operations, saturating

Behaviour:
- Reset (async, ext_reset=1):
  - state=IDLE.
  - core_xo/yo/zo, core_sel, rsp_data, rsp_sel, op_count = 0; rsp_valid=0; busy=0.
  - core_reset=1, which parks the core.
- All outputs are registered. req_ready=1 only in IDLE.
- IDLE:
  - core_reset=1.
  - On the edge where req_valid&req_ready: latch req_x/y/z/sel into core_xo/yo/zo/core_sel; go to START.
- START (exactly 1 cycle):
  - core_reset stays 1 while the new operands are already stable at the core.
  - Clear the cycle counter; go to RUN.
- RUN:
  - core_reset=0; the counter increments each cycle.
  - On the edge where counter==LATENCY-1: rsp_data<=core_z, rsp_sel<=core_sel, rsp_valid<=1, core_reset<=1; go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_sel are held stable.
  - On the edge where rsp_ready=1: rsp_valid<=0, op_count<=op_count+1 (saturates at 16'hFFFF); go to IDLE.
- Latency:
  - Accept edge = E0. core_reset is low for exactly LATENCY cycles (edges E1..E1+LATENCY).
  - rsp_valid rises at edge E0+LATENCY+1 and is visible in the following cycle.
  - Minimum request-to-request spacing is LATENCY+3 cycles (with rsp_ready held high).
- core_xo/yo/zo/core_sel hold their value from acceptance until the next acceptance; they do not change in DONE or IDLE.
- Requests are never queued. req_valid while busy is ignored, and the requester holds it.
- A simultaneous rsp_ready handshake and req_valid in DONE accepts only the response. The request is accepted on the next cycle in IDLE.
- rsp_ready while rsp_valid=0 has no effect.
- req_sel is passed through unchanged for all 4 codes, including 2'b11.
- ext_reset asserted mid-operation: the operation is abandoned and no response is produced. All outputs take reset values immediately, and core_reset goes high.
- Counter width is 8 bits. LATENCY=1 gives a single RUN cycle.

Test Plan:
1. Basic op, stub core (z=16'h1234 only after LATENCY low-reset cycles, else 16'hDEAD), LATENCY=32:
   - Stimulus: req x=16'h0300, y=16'h0100, z=16'h01C5, sel=00; rsp_ready=1.
   - Required: core_reset low for exactly 32 cycles; rsp_valid rises at E0+33; rsp_data=16'h1234; rsp_sel=00; op_count=1.
2. Back-pressure:
   - Stimulus: rsp_ready=0 for 10 cycles after rsp_valid.
   - Required: rsp_valid and rsp_data stable; req_ready=0 and busy=1 throughout; handshake on cycle 11; op_count increments once.
3. Back-to-back ops:
   - Stimulus: req x=16'h0080, y=16'h001D, z=16'h0200, sel=00 held valid during op 1.
   - Required: not accepted until IDLE; then accepted; core_xo=16'h0080 only after acceptance; second result correct; op_count=2.
4. Mid-run reset:
   - Stimulus: assert ext_reset at RUN cycle 15.
   - Required: rsp_valid never rises; all outputs take reset values; core_reset=1; next request completes normally.
5. Integration with real recon_top_level, sel=00, x=16'h0300, y=16'h0100, z=16'h01C5:
   - Required: rsp_data equals z from the standalone core run with the same operands.
6. op_count saturation:
   - Stimulus: force op_count to 16'hFFFE, run 3 ops.
   - Required: op_count reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/cordic_op_sequencer.sv
// Operand sequencer for the reconfigurable CORDIC core: loads one request,
// runs the core for LATENCY cycles, and returns the captured z result.
module cordic_op_sequencer #(
  parameter int unsigned WIDTH   = 15,
  parameter int unsigned LATENCY = 32
) (
  input  logic             clk,
  input  logic             ext_reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH:0]   req_x,
  input  logic [WIDTH:0]   req_y,
  input  logic [WIDTH:0]   req_z,
  input  logic [1:0]       req_sel,
  output logic [WIDTH:0]   core_xo,
  output logic [WIDTH:0]   core_yo,
  output logic [WIDTH:0]   core_zo,
  output logic [1:0]       core_sel,
  output logic             core_reset,
  input  logic [WIDTH:0]   core_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH:0]   rsp_data,
  output logic [1:0]       rsp_sel,
  output logic             busy,
  output logic [15:0]      op_count
);

  localparam int unsigned DW = WIDTH + 1;
  localparam int unsigned CW = 8;
  localparam int unsigned OCW = 16;
  localparam logic [CW-1:0]  CNT_LAST  = CW'(LATENCY - 1);
  localparam logic [OCW-1:0] OCNT_MAX  = {OCW{1'b1}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    core_xo_q, core_yo_q, core_zo_q;
  logic [1:0]       core_sel_q;
  logic             core_reset_q;
  logic             req_ready_q;
  logic             rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic [1:0]       rsp_sel_q;
  logic             busy_q;
  logic [OCW-1:0]   op_count_q;

  // Sequencer FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk or posedge ext_reset) begin
    if (ext_reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      core_xo_q    <= '0;
      core_yo_q    <= '0;
      core_zo_q    <= '0;
      core_sel_q   <= '0;
      core_reset_q <= 1'b1;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
      rsp_sel_q    <= '0;
      busy_q       <= 1'b0;
      op_count_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            core_xo_q   <= req_x;
            core_yo_q   <= req_y;
            core_zo_q   <= req_z;
            core_sel_q  <= req_sel;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= START;
          end
        end
        // Core stays parked one cycle so the new operands settle before release.
        START: begin
          cnt_q        <= '0;
          core_reset_q <= 1'b0;
          state_q      <= RUN;
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            rsp_data_q   <= core_z;
            rsp_sel_q    <= core_sel_q;
            rsp_valid_q  <= 1'b1;
            core_reset_q <= 1'b1;
            state_q      <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (op_count_q != OCNT_MAX) begin
              op_count_q <= op_count_q + OCW'(1);
            end
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign core_xo    = core_xo_q;
  assign core_yo    = core_yo_q;
  assign core_zo    = core_zo_q;
  assign core_sel   = core_sel_q;
  assign core_reset = core_reset_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_sel    = rsp_sel_q;
  assign busy       = busy_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_cordic_op_sequencer.sv
// Self-checking bench for cordic_op_sequencer with a stub CORDIC core whose z
// is only meaningful after LATENCY cycles of released reset.
module tb_cordic_op_sequencer;

  localparam int LAT = 32;

  logic        clk = 1'b0;
  logic        ext_reset;
  logic        req_valid, req_ready;
  logic [15:0] req_x, req_y, req_z;
  logic [1:0]  req_sel;
  logic [15:0] core_xo, core_yo, core_zo, core_z;
  logic [1:0]  core_sel;
  logic        core_reset;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [1:0]  rsp_sel;
  logic        busy;
  logic [15:0] op_count;

  // Second instance for the LATENCY=1 corner
  logic        l1_req_valid, l1_req_ready;
  logic [15:0] l1_req_x;
  logic [15:0] l1_core_xo, l1_core_yo, l1_core_zo, l1_core_z;
  logic [1:0]  l1_core_sel;
  logic        l1_core_reset;
  logic        l1_rsp_valid, l1_rsp_ready;
  logic [15:0] l1_rsp_data;
  logic [1:0]  l1_rsp_sel;
  logic        l1_busy;
  logic [15:0] l1_op_count;

  int tests = 0;
  int fails = 0;
  logic [15:0] model_cnt = 16'h0;
  int low_cnt = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] hash16(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] z, input logic [1:0] s);
    logic [15:0] a, b, c;
    a = x - 16'h0300;
    b = y - 16'h0100;
    c = z - 16'h01C5;
    return 16'h1234 ^ a ^ {b[14:0], b[15]} ^ {c[13:0], c[15:14]} ^ {s, 14'h0};
  endfunction

  // Stub core: correct result only during the LATENCY-th released cycle onward
  always @(posedge clk) low_cnt <= core_reset ? 0 : low_cnt + 1;
  assign core_z = (!core_reset && low_cnt >= LAT - 1)
                  ? hash16(core_xo, core_yo, core_zo, core_sel) : 16'hDEAD;
  assign l1_core_z = l1_core_reset ? 16'hDEAD : l1_core_xo;

  cordic_op_sequencer #(.WIDTH(15), .LATENCY(LAT)) dut (
    .clk(clk), .ext_reset(ext_reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_z(req_z), .req_sel(req_sel),
    .core_xo(core_xo), .core_yo(core_yo), .core_zo(core_zo), .core_sel(core_sel),
    .core_reset(core_reset), .core_z(core_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_sel(rsp_sel),
    .busy(busy), .op_count(op_count)
  );

  cordic_op_sequencer #(.WIDTH(15), .LATENCY(1)) u_l1 (
    .clk(clk), .ext_reset(ext_reset),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready),
    .req_x(l1_req_x), .req_y(16'h0), .req_z(16'h0), .req_sel(2'b01),
    .core_xo(l1_core_xo), .core_yo(l1_core_yo), .core_zo(l1_core_zo), .core_sel(l1_core_sel),
    .core_reset(l1_core_reset), .core_z(l1_core_z),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready), .rsp_data(l1_rsp_data),
    .rsp_sel(l1_rsp_sel), .busy(l1_busy), .op_count(l1_op_count)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Caller is positioned at a negedge; returns at the negedge after the accept edge.
  task automatic do_accept(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic [1:0] s);
    int w = 0;
    req_x = x; req_y = y; req_z = z; req_sel = s; req_valid = 1'b1;
    while (!req_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk("accept_timeout", 32'(w < 200), 32'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("start_operands", {core_xo, core_yo}, {x, y});
    chk("start_zsel", {14'h0, core_sel, core_zo}, {14'h0, s, z});
    chk("start_ctl", {29'h0, core_reset, busy, req_ready}, {29'h0, 3'b110});
  endtask

  task automatic finish_op(input logic [15:0] x, input logic [15:0] y,
                           input logic [15:0] z, input logic [1:0] s, input int delay);
    int rise = -1;
    int low  = 0;
    int bad  = 0;
    logic [15:0] exp = hash16(x, y, z, s);
    for (int k = 1; k <= LAT + 6; k++) begin
      @(negedge clk);
      if (!core_reset) low++;
      if (!busy || req_ready || core_xo !== x || core_zo !== z || core_sel !== s) bad++;
      if (rsp_valid) begin
        rise = k;
        break;
      end
    end
    chk("rsp_rise_cycle", 32'(rise), 32'(LAT + 1));
    chk("core_reset_low_cycles", 32'(low), 32'(LAT));
    chk("run_stable", 32'(bad), 32'd0);
    chk("rsp_data", 32'(rsp_data), 32'(exp));
    chk("rsp_sel", 32'(rsp_sel), 32'(s));
    bad = 0;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== exp || rsp_sel !== s || !busy || req_ready) bad++;
    end
    chk("backpressure_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'h1;
    chk("after_handshake", {29'h0, rsp_valid, busy, req_ready}, {29'h0, 3'b001});
    chk("op_count", 32'(op_count), 32'(model_cnt));
    chk("operands_held", 32'(core_xo), 32'(x));
  endtask

  typedef struct {
    logic [15:0] x, y, z;
    logic [1:0]  s;
    int          d;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    ext_reset = 1'b1;
    req_valid = 1'b0; req_x = '0; req_y = '0; req_z = '0; req_sel = '0;
    rsp_ready = 1'b0;
    l1_req_valid = 1'b0; l1_req_x = '0; l1_rsp_ready = 1'b1;

    tbl[0] = '{16'h0300, 16'h0100, 16'h01C5, 2'b00, 0, 16'h0};
    tbl[1] = '{16'h0300, 16'h0100, 16'h01C5, 2'b10, 10, 16'h0};
    tbl[2] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 2'b11, 1, 16'h0};
    tbl[3] = '{16'h0000, 16'h0000, 16'h0000, 2'b01, 2, 16'h0};
    for (int i = 4; i < 12; i++)
      tbl[i] = '{16'($urandom), 16'($urandom), 16'($urandom),
                 2'($urandom_range(3)), int'($urandom_range(3)), 16'h0};
    for (int i = 0; i < 12; i++) tbl[i].exp = hash16(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].s);
    chk("basic_expect", 32'(tbl[0].exp), 32'h1234);

    #3;
    chk("reset_core", {core_xo, core_zo}, 32'h0);
    chk("reset_rsp", {rsp_data, op_count}, 32'h0);
    chk("reset_ctl", {26'h0, core_sel, rsp_sel, core_reset, rsp_valid, busy, req_ready},
        {26'h0, 2'b00, 2'b00, 4'b1001});
    @(negedge clk);
    @(negedge clk);
    ext_reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_accept(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].s);
      finish_op(tbl[i].x, tbl[i].y, tbl[i].z, tbl[i].s, tbl[i].d);
      chk("table_rsp_data_held", 32'(rsp_data), 32'(tbl[i].exp));
    end

    // Back-to-back: second request held valid during the first operation
    do_accept(16'h0300, 16'h0100, 16'h01C5, 2'b00);
    req_x = 16'h0080; req_y = 16'h001D; req_z = 16'h0200; req_sel = 2'b00; req_valid = 1'b1;
    finish_op(16'h0300, 16'h0100, 16'h01C5, 2'b00, 0);
    do_accept(16'h0080, 16'h001D, 16'h0200, 2'b00);
    finish_op(16'h0080, 16'h001D, 16'h0200, 2'b00, 3);

    // rsp_ready pulsed while no response is pending
    rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_rsp_ready", {15'h0, rsp_valid, op_count}, {15'h0, 1'b0, model_cnt});

    // Reset in the middle of RUN abandons the operation
    do_accept(16'h1111, 16'h2222, 16'h3333, 2'b01);
    repeat (15) @(negedge clk);
    ext_reset = 1'b1;
    #1;
    model_cnt = 16'h0;
    chk("midreset_core", {core_xo, core_yo}, 32'h0);
    chk("midreset_out", {rsp_data, op_count}, 32'h0);
    chk("midreset_ctl", {28'h0, core_reset, rsp_valid, busy, req_ready}, {28'h0, 4'b1001});
    @(negedge clk);
    ext_reset = 1'b0;
    begin
      int seen = 0;
      for (int k = 0; k < LAT + 6; k++) begin
        @(negedge clk);
        if (rsp_valid || busy) seen++;
      end
      chk("midreset_no_rsp", 32'(seen), 32'd0);
    end
    do_accept(16'h0123, 16'h0456, 16'h0789, 2'b11);
    finish_op(16'h0123, 16'h0456, 16'h0789, 2'b11, 0);

    // op_count saturation
    force dut.op_count_q = 16'hFFFE;
    @(negedge clk);
    release dut.op_count_q;
    model_cnt = 16'hFFFE;
    chk("sat_preload", 32'(op_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      logic [15:0] x = 16'($urandom);
      do_accept(x, 16'h0100, 16'h01C5, 2'b00);
      finish_op(x, 16'h0100, 16'h01C5, 2'b00, 0);
    end
    chk("sat_final", 32'(op_count), 32'hFFFF);

    // LATENCY=1: a single released cycle
    begin
      int rise = -1;
      int low  = 0;
      chk("l1_ready", 32'(l1_req_ready), 32'd1);
      l1_req_x = 16'hBEEF;
      l1_req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      l1_req_valid = 1'b0;
      chk("l1_start_reset", 32'(l1_core_reset), 32'd1);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (!l1_core_reset) low++;
        if (l1_rsp_valid && rise < 0) begin
          rise = k;
          chk("l1_data", {l1_rsp_data, 14'h0, l1_rsp_sel}, {16'hBEEF, 14'h0, 2'b01});
        end
      end
      chk("l1_rise", 32'(rise), 32'd2);
      chk("l1_low", 32'(low), 32'd1);
      chk("l1_count", 32'(l1_op_count), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
